// File: rtl/gcd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gcd_pkg : shared state encoding and default operand width for gcd_unit.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package gcd_pkg;

  localparam int c_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_Y  = 2'd1,
    COMPUTE = 2'd2,
    DONE    = 2'd3
  } gcd_state_t;

endpackage
`default_nettype wire

// File: rtl/gcd_datapath.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gcd_datapath : X/Y operand registers with compare and subtract-by-larger. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module gcd_datapath
  import gcd_pkg::*;
#(
  parameter int WIDTH = c_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load_x,
  input  logic             i_load_y,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_x,
  output logic             o_eq
);

  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic             w_x_gt_y;
  logic             w_y_gt_x;

  assign w_x_gt_y = (r_x > r_y);
  assign w_y_gt_x = (r_y > r_x);

  // The larger operand is always the minuend, so no borrow is possible.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_load_x) begin
      r_x <= i_data;
    end else if (i_load_y) begin
      r_y <= i_data;
    end else if (i_step) begin
      if (w_x_gt_y) begin
        r_x <= r_x - r_y;
      end else if (w_y_gt_x) begin
        r_y <= r_y - r_x;
      end
    end
  end

  assign o_x  = r_x;
  assign o_eq = (r_x == r_y);

endmodule
`default_nettype wire

// File: rtl/gcd_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gcd_unit : subtractive GCD engine with two-strobe operand entry.          |
// | Optional step counter output Cycles: define GCD_UNIT_CYCLE_COUNT_EN.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module gcd_unit
  import gcd_pkg::*;
#(
  parameter int WIDTH = c_WIDTH_DEFAULT
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Enter,
  input  logic [WIDTH-1:0] Input,
  output logic [WIDTH-1:0] Output,
  output logic             Halt,
  output logic             Busy,
  output logic             Error
`ifdef GCD_UNIT_CYCLE_COUNT_EN
  ,
  output logic [WIDTH-1:0] Cycles
`endif
);

  gcd_state_t       r_state;
  gcd_state_t       w_next_state;
  logic [WIDTH-1:0] w_x;
  logic             w_eq;
  logic             w_load_x;
  logic             w_load_y;
  logic             w_step;
  logic             w_finish;
  logic [WIDTH-1:0] w_result;
  logic             w_error_next;
  logic [WIDTH-1:0] r_output;
  logic             r_halt;
  logic             r_error;

  gcd_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk      (Clock),
    .rst      (Reset),
    .i_load_x (w_load_x),
    .i_load_y (w_load_y),
    .i_step   (w_step),
    .i_data   (Input),
    .o_x      (w_x),
    .o_eq     (w_eq)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_load_x     = 1'b0;
    w_load_y     = 1'b0;
    w_step       = 1'b0;
    w_finish     = 1'b0;
    w_result     = r_output;
    w_error_next = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (Enter) begin
          w_load_x     = 1'b1;
          w_next_state = WAIT_Y;
        end
      end
      WAIT_Y: begin
        if (Enter) begin
          w_load_y = 1'b1;
          // A zero operand makes the answer the other operand; skip COMPUTE.
          if ((w_x == '0) || (Input == '0)) begin
            w_finish     = 1'b1;
            w_result     = w_x | Input;
            w_error_next = (w_x == '0) && (Input == '0);
            w_next_state = DONE;
          end else begin
            w_next_state = COMPUTE;
          end
        end
      end
      COMPUTE: begin
        w_step = 1'b1;
        if (w_eq) begin
          w_finish     = 1'b1;
          w_result     = w_x;
          w_next_state = DONE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_output <= '0;
      r_halt   <= 1'b0;
      r_error  <= 1'b0;
    end else if (w_finish) begin
      r_output <= w_result;
      r_halt   <= 1'b1;
      r_error  <= w_error_next;
    end else if (w_load_x) begin
      r_halt   <= 1'b0;
      r_error  <= 1'b0;
    end
  end

  assign Output = r_output;
  assign Halt   = r_halt;
  assign Error  = r_error;
  assign Busy   = (r_state == WAIT_Y) || (r_state == COMPUTE);

`ifdef GCD_UNIT_CYCLE_COUNT_EN
  logic [WIDTH-1:0] r_cycles;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_cycles <= '0;
    end else if (w_load_y) begin
      r_cycles <= '0;
    end else if (w_step && !w_eq && (r_cycles != '1)) begin
      r_cycles <= r_cycles + WIDTH'(1);
    end
  end

  assign Cycles = r_cycles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gcd_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_gcd_unit : directed and randomised checks of gcd_unit (WIDTH 8 and 16). |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_gcd_unit;

  logic        Clock;
  logic        Reset;
  logic        Enter;
  logic [7:0]  Input;
  logic [7:0]  Output;
  logic        Halt;
  logic        Busy;
  logic        Error;
  logic        Enter16;
  logic [15:0] Input16;
  logic [15:0] Output16;
  logic        Halt16;
  logic        Busy16;
  logic        Error16;
`ifdef GCD_UNIT_CYCLE_COUNT_EN
  logic [7:0]  Cycles;
  logic [15:0] Cycles16;
`endif

  int total = 0;
  int bad   = 0;

  gcd_unit #(.WIDTH(8)) dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .Enter  (Enter),
    .Input  (Input),
    .Output (Output),
    .Halt   (Halt),
    .Busy   (Busy),
    .Error  (Error)
`ifdef GCD_UNIT_CYCLE_COUNT_EN
    ,
    .Cycles (Cycles)
`endif
  );

  gcd_unit #(.WIDTH(16)) dut16 (
    .Clock  (Clock),
    .Reset  (Reset),
    .Enter  (Enter16),
    .Input  (Input16),
    .Output (Output16),
    .Halt   (Halt16),
    .Busy   (Busy16),
    .Error  (Error16)
`ifdef GCD_UNIT_CYCLE_COUNT_EN
    ,
    .Cycles (Cycles16)
`endif
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic int gcd_ref(input int a, input int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

`ifdef GCD_UNIT_CYCLE_COUNT_EN
  function automatic int sub_steps(input int a, input int b);
    int n = 0;
    while (a != b) begin
      if (a > b) a -= b;
      else       b -= a;
      n++;
    end
    return n;
  endfunction
`endif

  // Returns half a cycle after the edge that latched Y.
  task automatic enter_pair(input logic [7:0] a, input logic [7:0] b);
    @(negedge Clock);
    Enter = 1'b1;
    Input = a;
    @(negedge Clock);
    Input = b;
    @(negedge Clock);
    Enter = 1'b0;
  endtask

  task automatic wait_halt(input bit inject, input int limit, output int edges);
    edges = 0;
    while (!Halt && edges < limit) begin
      Enter = inject && ($urandom_range(0, 2) == 0);
      Input = 8'($urandom);
      @(negedge Clock);
      edges++;
    end
    Enter = 1'b0;
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    Enter = 1'b1;
    Input = 8'd99;
    Enter16 = 1'b0;
    Input16 = '0;
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    Enter = 1'b0;
    total++; if (Output !== 8'd0) begin bad++; $display("FAIL reset_output got=%0d exp=0", Output); end
    total++; if (Halt !== 1'b0)   begin bad++; $display("FAIL reset_halt got=%b exp=0", Halt); end
    total++; if (Busy !== 1'b0)   begin bad++; $display("FAIL reset_busy_priority got=%b exp=0", Busy); end
    total++; if (Error !== 1'b0)  begin bad++; $display("FAIL reset_error got=%b exp=0", Error); end
  endtask

  task automatic test_basic;
    int edges;
    enter_pair(8'd12, 8'd8);
    total++; if (Output !== 8'd0) begin bad++; $display("FAIL basic_no_early_output got=%0d exp=0", Output); end
    wait_halt(1'b0, 50, edges);
    total++; if (edges != 3)      begin bad++; $display("FAIL basic_latency got=%0d exp=3", edges); end
    total++; if (Output !== 8'd4) begin bad++; $display("FAIL basic_output got=%0d exp=4", Output); end
    total++; if (Error !== 1'b0 || Halt !== 1'b1 || Busy !== 1'b0)
      begin bad++; $display("FAIL basic_flags got err=%b halt=%b busy=%b exp 0 1 0", Error, Halt, Busy); end
`ifdef GCD_UNIT_CYCLE_COUNT_EN
    total++; if (Cycles !== 8'd2) begin bad++; $display("FAIL basic_cycles got=%0d exp=2", Cycles); end
`endif
  endtask

  task automatic test_equal;
    int edges;
    enter_pair(8'd5, 8'd5);
    wait_halt(1'b0, 50, edges);
    total++; if (edges != 1)      begin bad++; $display("FAIL equal_latency got=%0d exp=1", edges); end
    total++; if (Output !== 8'd5) begin bad++; $display("FAIL equal_output got=%0d exp=5", Output); end
`ifdef GCD_UNIT_CYCLE_COUNT_EN
    total++; if (Cycles !== 8'd0) begin bad++; $display("FAIL equal_cycles got=%0d exp=0", Cycles); end
`endif
  endtask

  task automatic test_zero;
    int edges;
    enter_pair(8'd0, 8'd9);
    wait_halt(1'b0, 50, edges);
    total++; if (edges != 0) begin bad++; $display("FAIL zero_latency got=%0d exp=0", edges); end
    total++; if (Output !== 8'd9 || Error !== 1'b0 || Busy !== 1'b0)
      begin bad++; $display("FAIL zero_x got out=%0d err=%b busy=%b exp 9 0 0", Output, Error, Busy); end
    enter_pair(8'd6, 8'd0);
    total++; if (Output !== 8'd6 || Error !== 1'b0 || Halt !== 1'b1)
      begin bad++; $display("FAIL zero_y got out=%0d err=%b halt=%b exp 6 0 1", Output, Error, Halt); end
    enter_pair(8'd0, 8'd0);
    total++; if (Output !== 8'd0 || Error !== 1'b1 || Halt !== 1'b1)
      begin bad++; $display("FAIL zero_both got out=%0d err=%b halt=%b exp 0 1 1", Output, Error, Halt); end
  endtask

  task automatic test_hold;
    int edges;
    repeat (4) @(negedge Clock);
    total++; if (Output !== 8'd0 || Error !== 1'b1 || Halt !== 1'b1)
      begin bad++; $display("FAIL hold_done got out=%0d err=%b halt=%b exp 0 1 1", Output, Error, Halt); end
    Enter = 1'b1;
    Input = 8'd9;
    @(negedge Clock);
    Enter = 1'b0;
    total++; if (Halt !== 1'b0 || Error !== 1'b0 || Busy !== 1'b1 || Output !== 8'd0)
      begin bad++; $display("FAIL hold_new_x got halt=%b err=%b busy=%b out=%0d exp 0 0 1 0", Halt, Error, Busy, Output); end
    Enter = 1'b1;
    Input = 8'd3;
    @(negedge Clock);
    Enter = 1'b0;
    wait_halt(1'b0, 50, edges);
    total++; if (edges != 3 || Output !== 8'd3)
      begin bad++; $display("FAIL hold_followup got edges=%0d out=%0d exp 3 3", edges, Output); end
  endtask

  task automatic test_long;
    int   edges;
    bit   busy_ok;
    bit   out_ok;
    logic [7:0] prev;
    prev    = Output;
    enter_pair(8'd255, 8'd1);
    busy_ok = 1'b1;
    out_ok  = 1'b1;
    edges   = 0;
    while (!Halt && edges < 400) begin
      if (Busy !== 1'b1) busy_ok = 1'b0;
      if (Output !== prev) out_ok = 1'b0;
      @(negedge Clock);
      edges++;
    end
    total++; if (edges != 255)    begin bad++; $display("FAIL long_latency got=%0d exp=255", edges); end
    total++; if (!busy_ok)        begin bad++; $display("FAIL long_busy got=0 exp=1 throughout"); end
    total++; if (!out_ok)         begin bad++; $display("FAIL long_output_stable got=changed exp=%0d", prev); end
    total++; if (Output !== 8'd1) begin bad++; $display("FAIL long_output got=%0d exp=1", Output); end
`ifdef GCD_UNIT_CYCLE_COUNT_EN
    total++; if (Cycles !== 8'd254) begin bad++; $display("FAIL long_cycles got=%0d exp=254", Cycles); end
`endif
  endtask

  task automatic test_reset_abort;
    int edges;
    enter_pair(8'd48, 8'd18);
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    total++; if (Output !== 8'd0 || Halt !== 1'b0 || Busy !== 1'b0 || Error !== 1'b0)
      begin bad++; $display("FAIL abort_outputs got out=%0d halt=%b busy=%b err=%b exp 0 0 0 0", Output, Halt, Busy, Error); end
`ifdef GCD_UNIT_CYCLE_COUNT_EN
    total++; if (Cycles !== 8'd0) begin bad++; $display("FAIL abort_cycles got=%0d exp=0", Cycles); end
`endif
    repeat (8) @(negedge Clock);
    total++; if (Halt !== 1'b0 || Output !== 8'd0)
      begin bad++; $display("FAIL abort_no_result got halt=%b out=%0d exp 0 0", Halt, Output); end
    enter_pair(8'd7, 8'd21);
    wait_halt(1'b0, 50, edges);
    total++; if (edges != 3 || Output !== 8'd7)
      begin bad++; $display("FAIL abort_restart got edges=%0d out=%0d exp 3 7", edges, Output); end
  endtask

  task automatic test_random_w8;
    int a, b, exp_g, edges;
    for (int i = 0; i < 100; i++) begin
      a = int'($urandom_range(1, 255));
      b = int'($urandom_range(1, 255));
      exp_g = gcd_ref(a, b);
      enter_pair(8'(a), 8'(b));
      wait_halt(1'b1, 300, edges);
      total++; if (Output !== 8'(exp_g) || Halt !== 1'b1 || Busy !== 1'b0)
        begin bad++; $display("FAIL rand8 a=%0d b=%0d got out=%0d halt=%b busy=%b exp %0d 1 0", a, b, Output, Halt, Busy, exp_g); end
`ifdef GCD_UNIT_CYCLE_COUNT_EN
      total++; if (Cycles !== 8'(sub_steps(a, b)))
        begin bad++; $display("FAIL rand8_cycles a=%0d b=%0d got=%0d exp=%0d", a, b, Cycles, sub_steps(a, b)); end
`endif
    end
  endtask

  task automatic test_random_w16;
    int a, b, exp_g, edges;
    for (int i = 0; i < 100; i++) begin
      a = int'($urandom_range(1024, 65535));
      b = int'($urandom_range(1024, 65535));
      exp_g = gcd_ref(a, b);
      @(negedge Clock);
      Enter16 = 1'b1;
      Input16 = 16'(a);
      @(negedge Clock);
      Input16 = 16'(b);
      @(negedge Clock);
      Enter16 = 1'b0;
      edges = 0;
      while (!Halt16 && edges < 5000) begin
        Enter16 = ($urandom_range(0, 2) == 0);
        Input16 = 16'($urandom);
        @(negedge Clock);
        edges++;
      end
      Enter16 = 1'b0;
      total++; if (Output16 !== 16'(exp_g) || Halt16 !== 1'b1 || Busy16 !== 1'b0 || Error16 !== 1'b0)
        begin bad++; $display("FAIL rand16 a=%0d b=%0d got out=%0d halt=%b busy=%b err=%b exp %0d 1 0 0", a, b, Output16, Halt16, Busy16, Error16, exp_g); end
    end
  endtask

  initial begin
    Reset   = 1'b0;
    Enter   = 1'b0;
    Input   = '0;
    Enter16 = 1'b0;
    Input16 = '0;
    test_reset;
    test_basic;
    test_equal;
    test_zero;
    test_hold;
    test_long;
    test_reset_abort;
    test_random_w8;
    test_random_w16;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
